// File: rtl/flash_reader_pkg.sv
// Shared types and constants for the flash byte reader.
// Holds the FSM state encoding and the byte-lane indices.
package flash_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_REQ       = 3'd2,
    ST_WAIT_DATA = 3'd3,
    ST_DONE      = 3'd4
  } flash_rd_state_t;

  localparam logic [3:0] FLASH_BYTEENABLE_ALL = 4'hF;

  localparam logic [1:0] LANE_0 = 2'd0;
  localparam logic [1:0] LANE_1 = 2'd1;
  localparam logic [1:0] LANE_2 = 2'd2;
  localparam logic [1:0] LANE_3 = 2'd3;

endpackage

// File: rtl/flash_byte_reader_if.sv
// Avalon-MM read-only bus between the byte reader (master) and the flash slave.
interface flash_byte_reader_if #(
  parameter int WORD_ADDR_W = 19
);
  logic                   flash_mem_read;
  logic [WORD_ADDR_W-1:0] flash_mem_address;
  logic [3:0]             flash_mem_byteenable;
  logic                   flash_mem_waitrequest;
  logic [31:0]            flash_mem_readdata;
  logic                   flash_mem_readdatavalid;

  modport master (
    output flash_mem_read,
    output flash_mem_address,
    output flash_mem_byteenable,
    input  flash_mem_waitrequest,
    input  flash_mem_readdata,
    input  flash_mem_readdatavalid
  );

  modport slave (
    input  flash_mem_read,
    input  flash_mem_address,
    input  flash_mem_byteenable,
    output flash_mem_waitrequest,
    output flash_mem_readdata,
    output flash_mem_readdatavalid
  );
endinterface

// File: rtl/flash_word_cache.sv
// One-word cache (valid/tag/data) with hit compare and byte-lane select.
// Bypass routes the incoming fill word to the lane mux so a fill can be delivered same-edge.
module flash_word_cache
  import flash_reader_pkg::*;
#(
  parameter int TAG_W = 19
) (
  input  logic             clk,
  input  logic             reset_all,
  input  logic             fill,
  input  logic [TAG_W-1:0] fill_tag,
  input  logic [31:0]      fill_data,
  input  logic             invalidate,
  input  logic [TAG_W-1:0] lookup_tag,
  output logic             hit,
  input  logic             bypass,
  input  logic [1:0]       lane,
  output logic [7:0]       lane_byte
);

  logic             valid;
  logic [TAG_W-1:0] tag;
  logic [31:0]      data;
  logic [31:0]      word;

  // Invalidate has priority over a same-cycle fill; the data is still captured.
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (fill) begin
        tag  <= fill_tag;
        data <= fill_data;
      end
      if (invalidate) begin
        valid <= 1'b0;
      end else if (fill) begin
        valid <= 1'b1;
      end
    end
  end

  assign hit  = valid && (tag == lookup_tag);
  assign word = bypass ? fill_data : data;

  always_comb begin
    lane_byte = word[7:0];
    case (lane)
      LANE_0:  lane_byte = word[7:0];
      LANE_1:  lane_byte = word[15:8];
      LANE_2:  lane_byte = word[23:16];
      LANE_3:  lane_byte = word[31:24];
      default: lane_byte = word[7:0];
    endcase
  end

endmodule

// File: rtl/flash_byte_reader.sv
// Fetches one byte from Avalon-MM flash per request, reusing a one-word cache
// so the two bytes of a 16-bit sample usually cost a single flash access.
//
// state        | meaning
// ST_IDLE      | waiting for read_start, address captured on accept
// ST_LOOKUP    | compare captured word address against the cache
// ST_REQ       | flash_mem_read asserted until waitrequest drops
// ST_WAIT_DATA | waiting for readdatavalid, timeout counter running
// ST_DONE      | finish_read pulse, audio_byte already updated
module flash_byte_reader
  import flash_reader_pkg::*;
#(
  parameter int BYTE_ADDR_W    = 21,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   reset_all,
  input  logic                   read_start,
  input  logic [BYTE_ADDR_W-1:0] byte_addr,
  input  logic                   cache_invalidate,
  output logic [7:0]             audio_byte,
  output logic                   finish_read,
  output logic                   busy,
  output logic                   error,
  flash_byte_reader_if.master    flash_bus
);

  localparam int WORD_ADDR_W = BYTE_ADDR_W - 2;
  localparam int CNT_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  flash_rd_state_t        state;
  flash_rd_state_t        state_nx;
  logic [BYTE_ADDR_W-1:0] addr_q;
  logic [WORD_ADDR_W-1:0] word_addr;
  logic [CNT_W-1:0]       wait_cnt;
  logic                   cache_hit;
  logic                   fill;
  logic                   timed_out;
  logic [7:0]             lane_byte;

  assign word_addr = addr_q[BYTE_ADDR_W-1:2];
  assign fill      = (state == ST_WAIT_DATA) && flash_bus.flash_mem_readdatavalid;
  assign timed_out = (state == ST_WAIT_DATA) && !flash_bus.flash_mem_readdatavalid &&
                     (wait_cnt == CNT_LAST);

  flash_word_cache #(
    .TAG_W (WORD_ADDR_W)
  ) u_cache (
    .clk        (clk),
    .reset_all  (reset_all),
    .fill       (fill),
    .fill_tag   (word_addr),
    .fill_data  (flash_bus.flash_mem_readdata),
    .invalidate (cache_invalidate || timed_out),
    .lookup_tag (word_addr),
    .hit        (cache_hit),
    .bypass     (fill),
    .lane       (addr_q[1:0]),
    .lane_byte  (lane_byte)
  );

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (read_start) state_nx = ST_LOOKUP;
      end
      ST_LOOKUP: begin
        state_nx = (cache_hit && !cache_invalidate) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        if (!flash_bus.flash_mem_waitrequest) state_nx = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (fill || timed_out) state_nx = ST_DONE;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      addr_q     <= '0;
      wait_cnt   <= '0;
      error      <= 1'b0;
      audio_byte <= 8'h00;
    end else begin
      if (state == ST_IDLE && read_start) begin
        addr_q <= byte_addr;
      end
      if (state == ST_REQ) begin
        wait_cnt <= '0;
      end else if (state == ST_WAIT_DATA) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (timed_out) begin
        error <= 1'b1;
      end
      // A timed-out access delivers zero rather than stale cache contents.
      if (state_nx == ST_DONE && state != ST_DONE) begin
        audio_byte <= timed_out ? 8'h00 : lane_byte;
      end
    end
  end

  assign finish_read                    = (state == ST_DONE);
  assign busy                           = (state != ST_IDLE);
  assign flash_bus.flash_mem_read       = (state == ST_REQ);
  assign flash_bus.flash_mem_address    = word_addr;
  assign flash_bus.flash_mem_byteenable = FLASH_BYTEENABLE_ALL;

endmodule

// File: tb/tb_flash_byte_reader.sv
// Directed bench for flash_byte_reader with a cycle-driven flash slave and byte scoreboard.
module tb_flash_byte_reader;

  localparam int TO = 1024;

  logic        clk;
  logic        reset_all;
  logic        read_start;
  logic [20:0] byte_addr;
  logic        cache_invalidate;
  logic [7:0]  audio_byte;
  logic        finish_read;
  logic        busy;
  logic        error;

  int total;
  int bad;
  logic [7:0] sb[$];

  flash_byte_reader_if #(.WORD_ADDR_W(19)) bus ();

  flash_byte_reader #(
    .BYTE_ADDR_W    (21),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk              (clk),
    .reset_all        (reset_all),
    .read_start       (read_start),
    .byte_addr        (byte_addr),
    .cache_invalidate (cache_invalidate),
    .audio_byte       (audio_byte),
    .finish_read      (finish_read),
    .busy             (busy),
    .error            (error),
    .flash_bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_read(input string tag, input logic [20:0] a, input logic [31:0] rdata,
                          input int stall, input bit respond, input bit inv_lookup,
                          input bit inv_fill, input bit exp_miss, input logic [7:0] exp_byte,
                          input bit poke_done);
    int acc;
    int stalls;
    int exp_fin;
    bit read_seen;
    bit done;
    logic [7:0] exp_q;
    acc = -1;
    stalls = 0;
    read_seen = 1'b0;
    done = 1'b0;
    exp_fin = !exp_miss ? 2 : (respond ? 5 + stall : 3 + stall + TO);
    @(negedge clk);
    read_start = 1'b1;
    byte_addr = a;
    sb.push_back(exp_byte);
    for (int c = 1; c <= TO + 100 && !done; c++) begin
      @(negedge clk);
      read_start = 1'b0;
      cache_invalidate = 1'b0;
      bus.flash_mem_readdatavalid = 1'b0;
      bus.flash_mem_waitrequest = 1'b0;
      bus.flash_mem_readdata = $urandom;
      if (c == 1 && inv_lookup) cache_invalidate = 1'b1;
      if (bus.flash_mem_read) begin
        check({tag, "/addr"}, 32'(bus.flash_mem_address), 32'(a[20:2]));
        read_seen = 1'b1;
        if (stalls < stall) begin
          bus.flash_mem_waitrequest = 1'b1;
          stalls++;
        end else begin
          acc = c;
        end
      end else if (acc >= 0 && c == acc + 1) begin
        check({tag, "/read_drop"}, 32'(bus.flash_mem_read), 32'd0);
      end
      if (respond && acc >= 0 && c == acc + 2) begin
        bus.flash_mem_readdatavalid = 1'b1;
        bus.flash_mem_readdata = rdata;
        if (inv_fill) cache_invalidate = 1'b1;
      end
      if (finish_read) begin
        done = 1'b1;
        check({tag, "/fin_cycle"}, 32'(c), 32'(exp_fin));
        check({tag, "/miss"}, 32'(read_seen), 32'(exp_miss));
        check({tag, "/sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          exp_q = sb.pop_front();
          check({tag, "/byte"}, 32'(audio_byte), 32'(exp_q));
        end
        if (poke_done) begin
          read_start = 1'b1;
          byte_addr = a;
        end
      end
    end
    check({tag, "/finished"}, 32'(done), 32'd1);
    @(negedge clk);
    read_start = 1'b0;
    bus.flash_mem_readdatavalid = 1'b0;
    check({tag, "/pulse_once"}, 32'(finish_read), 32'd0);
    check({tag, "/idle_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset_all = 1'b0;
    read_start = 1'b0;
    byte_addr = '0;
    cache_invalidate = 1'b0;
    bus.flash_mem_waitrequest = 1'b0;
    bus.flash_mem_readdata = '0;
    bus.flash_mem_readdatavalid = 1'b0;

    #3;
    check("rst/audio_byte", 32'(audio_byte), 32'd0);
    check("rst/finish_read", 32'(finish_read), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/error", 32'(error), 32'd0);
    check("rst/mem_read", 32'(bus.flash_mem_read), 32'd0);
    check("rst/mem_address", 32'(bus.flash_mem_address), 32'd0);
    check("rst/byteenable", 32'(bus.flash_mem_byteenable), 32'hF);
    @(negedge clk);
    @(negedge clk);
    reset_all = 1'b1;
    @(negedge clk);

    run_read("cold", 21'h000004, 32'hDDCCBBAA, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
    run_read("hit1", 21'h000005, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hBB, 1'b0);
    run_read("hit3", 21'h000007, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'hDD, 1'b1);
    run_read("stall", 21'h1FFFFF, 32'h44332211, 7, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 1'b0);
    check("pre_to/error", 32'(error), 32'd0);

    run_read("timeout", 21'h000010, 32'h0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    check("timeout/error", 32'(error), 32'd1);
    run_read("after_to", 21'h000011, 32'hA5A4A3A2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 1'b0);
    check("after_to/error_sticky", 32'(error), 32'd1);

    run_read("inv_lookup", 21'h000012, 32'hA5A4A3A2, 0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA4, 1'b0);
    run_read("inv_fill", 21'h000020, 32'h0F0E0D0C, 0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0);
    run_read("post_inv", 21'h000021, 32'h0F0E0D0C, 2, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0);

    @(negedge clk);
    read_start = 1'b1;
    byte_addr = 21'h000100;
    @(negedge clk);
    read_start = 1'b0;
    @(negedge clk);
    check("mid_rst/req", 32'(bus.flash_mem_read), 32'd1);
    @(negedge clk);
    check("mid_rst/wait_busy", 32'(busy), 32'd1);
    #2 reset_all = 1'b0;
    #1;
    check("mid_rst/mem_read", 32'(bus.flash_mem_read), 32'd0);
    check("mid_rst/busy", 32'(busy), 32'd0);
    check("mid_rst/finish", 32'(finish_read), 32'd0);
    check("mid_rst/error", 32'(error), 32'd0);
    check("mid_rst/audio_byte", 32'(audio_byte), 32'd0);
    check("mid_rst/address", 32'(bus.flash_mem_address), 32'd0);
    @(negedge clk);
    reset_all = 1'b1;
    bus.flash_mem_readdatavalid = 1'b1;
    bus.flash_mem_readdata = 32'h11223344;
    @(negedge clk);
    bus.flash_mem_readdatavalid = 1'b0;
    check("late_rdv/finish", 32'(finish_read), 32'd0);
    check("late_rdv/busy", 32'(busy), 32'd0);
    check("late_rdv/audio_byte", 32'(audio_byte), 32'd0);

    run_read("rst_cold_cached", 21'h000021, 32'h0F0E0D0C, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h0D, 1'b0);
    run_read("rst_cold", 21'h000100, 32'h55667788, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h88, 1'b0);
    run_read("rst_hit", 21'h000101, 32'h0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h77, 1'b0);
    check("end/sb_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
